cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//  Multicycle control FSM for the Retro16 core. It sequences fetch, decode, execute, memory and writeback
//  around the instruction decoder, ALU, register file and single-port RAM.
//  It consumes the decoder's ram_read/ram_write flags and the branch bit (instruction[15]). It drives the
//  RAM req/ack handshake, IR load, condition-flag load, register write-back, PC increment and a
//  retired-instruction counter.
// PARAMETERS
//  MEM_TIMEOUT  255  cycles a FETCH/MEM access may wait for mem_ack before FAULT (only with SEQ_TIMEOUT_EN)
//  CNT_W        16   width of retired_count
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  reset_n        in   1      asynchronous, active-low reset
//  run            in   1      1 = execute instructions; 0 = stop at next instruction boundary
//  dec_ram_read   in   1      decoder ram_read (load instruction)
//  dec_ram_write  in   1      decoder ram_write (store instruction)
//  dec_branch     in   1      instruction[15] from IR (branch; destination is PC/R6)
//  mem_ack        in   1      RAM completes current access this cycle (read data valid)
//  mem_req        out  1      RAM access request, held until mem_ack
//  mem_we         out  1      1 = write access (valid only with mem_req)
//  mem_addr_sel   out  1      0 = address from PC (fetch), 1 = address from ALU result (data)
//  ir_load        out  1      load IR from RAM read data
//  mdr_load       out  1      load memory data register from RAM read data
//  cond_load      out  1      update cond_bits from ALU flags
//  reg_write      out  1      write destination_reg in register file
//  pc_inc         out  1      PC <= PC + 1
//  busy           out  1      1 whenever state != IDLE
//  state          out  3      current state encoding, for debug
//  retired_count  out  CNT_W  instructions completed since reset
//  bus_error      out  1      sticky RAM timeout flag (0 without SEQ_TIMEOUT_EN)
// BEHAVIOUR
//  States: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, FAULT=6.
//  Reset: state=IDLE, retired_count=0, latched flags=0, bus_error=0, all outputs 0.
//  Outputs are decoded from state and latched flags. The only input-dependent outputs are ir_load and mdr_load.
//  IDLE:      run=1 -> FETCH; otherwise stay.
//  FETCH:     mem_req=1, mem_addr_sel=0, mem_we=0; ir_load=mem_ack; on mem_ack -> DECODE, else stay.
//  DECODE:    1 cycle; latch ld=dec_ram_read, st=dec_ram_write, br=dec_branch; -> EXECUTE.
//  EXECUTE:   1 cycle; cond_load=~br; -> MEM if (ld|st), else WRITEBACK.
//  MEM:       mem_req=1, mem_addr_sel=1, mem_we=st; mdr_load=mem_ack&~st; on mem_ack -> WRITEBACK.
//  WRITEBACK: 1 cycle; reg_write=~st; pc_inc=~br; retired_count += 1; -> FETCH if run, else IDLE.
//  Latency with zero-wait RAM (ack in the first request cycle): ALU/branch instruction = 4 cycles, load/store = 5.
//  Each wait cycle adds 1.
//  Handshake: mem_req and mem_we stay stable until the ack cycle. mem_req drops in the cycle after ack.
//  mem_ack outside FETCH/MEM is ignored.
//  ld & st both 1 (not produced by the decoder): treated as a store, so mem_we=1, mdr_load=0, reg_write=0.
//  A branch writes R6 through reg_write with the ALU result. pc_inc stays 0 for a branch.
//  run deasserted mid-instruction: the instruction completes through WRITEBACK, then the FSM goes to IDLE.
//  run is sampled only in IDLE and WRITEBACK.
//  retired_count wraps from 2^CNT_W-1 to 0 without a flag.
//  Asynchronous reset mid-access drops mem_req immediately. The RAM aborts and no partial write is owed.
//  Encoding 7 is illegal and returns to IDLE on the next clock.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined:
//   - A wait counter clears on entry to FETCH/MEM and counts each cycle without mem_ack.
//   - When the counter reaches MEM_TIMEOUT, the FSM goes to FAULT. In FAULT all strobes are 0,
//     bus_error=1 (sticky), busy=1, and only reset_n leaves FAULT.
//  SEQ_TIMEOUT_EN undefined: no counter, waits are unbounded, FAULT is unreachable, bus_error is tied to 0.
// TESTING
//  1. Reset, run=1, ALU instr, mem_ack held 1 -> states 1,2,3,5,1; reg_write, pc_inc pulse once; retired_count=1.
//  2. Load, mem_ack 1 in FETCH, 3-cycle delay in MEM -> mem_addr_sel=1 4 cycles; mdr_load one pulse; reg_write next.
//  3. Store (dec_ram_write=1) -> mem_we=1 only in MEM; reg_write=0; pc_inc=1; cond_load=1 in EXECUTE.
//  4. Branch (dec_branch=1) -> cond_load=0, reg_write=1, pc_inc=0 in WRITEBACK; no MEM state.
//  5. Drop run during EXECUTE -> WRITEBACK completes, then IDLE, busy=0; reset_n low mid-MEM -> mem_req=0 at once.
//  6. SEQ_TIMEOUT_EN, MEM_TIMEOUT=4, mem_ack=0 in FETCH -> FAULT after 4 wait cycles, bus_error=1 until reset.

Source files
------------

// File: rtl/cpu_sequencer.sv
// Multicycle fetch/decode/execute/mem/writeback control FSM for the Retro16 core.
// Optional RAM-timeout fault detection is enabled by defining SEQ_TIMEOUT_EN.
module cpu_sequencer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             dec_ram_read,
    input  logic             dec_ram_write,
    input  logic             dec_branch,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_load,
    output logic             mdr_load,
    output logic             cond_load,
    output logic             reg_write,
    output logic             pc_inc,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_count,
    output logic             bus_error
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEM       = 3'd4,
        WRITEBACK = 3'd5,
        FAULT     = 3'd6
    } state_t;

    state_t           state_reg, state_next;
    logic             ld_reg, st_reg, br_reg;
    logic [CNT_W-1:0] retired_count_reg;
    logic             timeout_hit;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [TW-1:0] wait_cnt_reg;
    logic          bus_error_reg;

    // Hit fires on the last permitted wait cycle so FAULT follows after MEM_TIMEOUT misses.
    assign timeout_hit = (wait_cnt_reg == TW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_reg  <= '0;
            bus_error_reg <= 1'b0;
        end else begin
            if ((state_reg == FETCH || state_reg == MEM) && !mem_ack)
                wait_cnt_reg <= wait_cnt_reg + TW'(1);
            else
                wait_cnt_reg <= '0;
            if (state_next == FAULT)
                bus_error_reg <= 1'b1;
        end
    end

    assign bus_error = bus_error_reg;
`else
    assign timeout_hit = 1'b0;
    assign bus_error   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            ld_reg            <= 1'b0;
            st_reg            <= 1'b0;
            br_reg            <= 1'b0;
            retired_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == DECODE) begin
                ld_reg <= dec_ram_read;
                st_reg <= dec_ram_write;
                br_reg <= dec_branch;
            end
            if (state_reg == WRITEBACK)
                retired_count_reg <= retired_count_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next   = state_reg;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_load      = 1'b0;
        mdr_load     = 1'b0;
        cond_load    = 1'b0;
        reg_write    = 1'b0;
        pc_inc       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (run)
                    state_next = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                ir_load = mem_ack;
                if (mem_ack)
                    state_next = DECODE;
                else if (timeout_hit)
                    state_next = FAULT;
            end
            DECODE: begin
                state_next = EXECUTE;
            end
            EXECUTE: begin
                cond_load  = ~br_reg;
                state_next = (ld_reg | st_reg) ? MEM : WRITEBACK;
            end
            MEM: begin
                // A stray ld+st combination behaves as a store.
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = st_reg;
                mdr_load     = mem_ack & ~st_reg;
                if (mem_ack)
                    state_next = WRITEBACK;
                else if (timeout_hit)
                    state_next = FAULT;
            end
            WRITEBACK: begin
                reg_write  = ~st_reg;
                pc_inc     = ~br_reg;
                state_next = run ? FETCH : IDLE;
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy          = (state_reg != IDLE);
    assign state         = state_reg;
    assign retired_count = retired_count_reg;

endmodule
